// File: rtl/selfu_pkg.sv
// rtl/selfu_pkg.sv - shared constants and types for the select/move functional unit
// Contents:
//   FLAG_WB_PC / FLAG_IMM / FLAG_CSEL : bit positions inside the flags field
//   pend_t                            : per-entry outstanding-writeback bits
//   any_pend()                        : true while either channel still owes a transfer
package selfu_pkg;

    localparam int FLAG_WB_PC = 0;
    localparam int FLAG_IMM   = 1;
    localparam int FLAG_CSEL  = 2;

    typedef struct packed {
        logic cdb_pend;
        logic rob_pend;
    } pend_t;

    function automatic logic any_pend(input pend_t p);
        return p.cdb_pend | p.rob_pend;
    endfunction

endpackage

// File: rtl/fu_outq.sv
// rtl/fu_outq.sv - DEPTH-entry output queue draining to CDB and ROB via independent handshakes
// Optional macro: SELFU_Q_PERF_EN adds perf_issued / perf_stall / perf_cdb_wait counters.
// Ports:
//   clk, rst (async, active-low)
//   push_valid, push_robid, push_flags, push_wbs, push_value, push_cdb_pend : tail write
//   cdb_transmit (ready) / cdb_transmit_out (valid), cdb_id, cdb_val          : CDB channel
//   rob_transmit (ready) / rob_transmit_out (valid), robid_out, flags_out,
//   wbs_out, value_out                                                       : ROB channel
//   busy : queue full, pushes are ignored
module fu_outq
    import selfu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ROBID_W = 4,
    parameter int FLAG_W  = 8,
    parameter int WBS_W   = 8,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_valid,
    input  logic [ROBID_W-1:0] push_robid,
    input  logic [FLAG_W-1:0]  push_flags,
    input  logic [WBS_W-1:0]   push_wbs,
    input  logic [DATA_W-1:0]  push_value,
    input  logic               push_cdb_pend,
    input  logic               cdb_transmit,
    output logic               cdb_transmit_out,
    output logic [ROBID_W-1:0] cdb_id,
    output logic [DATA_W-1:0]  cdb_val,
    input  logic               rob_transmit,
    output logic               rob_transmit_out,
    output logic [ROBID_W-1:0] robid_out,
    output logic [FLAG_W-1:0]  flags_out,
    output logic [WBS_W-1:0]   wbs_out,
    output logic [DATA_W-1:0]  value_out,
    output logic               busy
`ifdef SELFU_Q_PERF_EN
    ,
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_cdb_wait
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ROBID_W-1:0] robid;
        logic [FLAG_W-1:0]  flags;
        logic [WBS_W-1:0]   wbs;
        logic [DATA_W-1:0]  value;
        pend_t              pend;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               busy_q;

    entry_t             head;
    logic               head_valid;
    logic               cdb_xfer;
    logic               rob_xfer;
    pend_t              pend_next;
    logic               push;
    logic               pop;
    entry_t             new_entry;

    always_comb begin
        head       = mem[rd_ptr];
        head_valid = (count != '0);

        cdb_transmit_out = head_valid & head.pend.cdb_pend;
        rob_transmit_out = head_valid & head.pend.rob_pend;

        cdb_xfer = cdb_transmit_out & cdb_transmit;
        rob_xfer = rob_transmit_out & rob_transmit;

        // Pending bits as they will stand after this cycle's transfers; the head
        // retires once neither channel is still owed anything.
        pend_next.cdb_pend = head.pend.cdb_pend & ~cdb_xfer;
        pend_next.rob_pend = head.pend.rob_pend & ~rob_xfer;
        pop  = head_valid & ~any_pend(pend_next);

        // busy is the registered full flag, so a pop in the full cycle cannot
        // make room for a push in that same cycle.
        push = push_valid & ~busy_q;

        new_entry.robid         = push_robid;
        new_entry.flags         = push_flags;
        new_entry.wbs           = push_wbs;
        new_entry.value         = push_value;
        new_entry.pend.cdb_pend = push_cdb_pend;
        new_entry.pend.rob_pend = 1'b1;

        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            busy_q <= 1'b0;
        end else begin
            // The head slot and the tail slot only coincide when the queue is
            // empty or full, and neither case has both writes active.
            if (head_valid && !pop) begin
                mem[rd_ptr].pend <= pend_next;
            end
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count  <= count_next;
            busy_q <= (count_next == CNT_W'(DEPTH));
        end
    end

    always_comb begin
        busy      = busy_q;
        cdb_id    = head_valid ? head.robid : '0;
        cdb_val   = head_valid ? head.value : '0;
        robid_out = head_valid ? head.robid : '0;
        flags_out = head_valid ? head.flags : '0;
        wbs_out   = head_valid ? head.wbs   : '0;
        value_out = head_valid ? head.value : '0;
    end

`ifdef SELFU_Q_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issued   <= '0;
            perf_stall    <= '0;
            perf_cdb_wait <= '0;
        end else begin
            if (push) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (push_valid && busy_q) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (cdb_transmit_out && !cdb_transmit) begin
                perf_cdb_wait <= perf_cdb_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/selfu_q.sv
// rtl/selfu_q.sv - select/move functional unit: result mux feeding a dual-drain output queue
// Optional macro: SELFU_Q_PERF_EN adds perf_issued / perf_stall / perf_cdb_wait outputs.
// Ports:
//   clk, rst (async, active-low)
//   input_transmit, operand, depvals[2:0], wbs, flags, robid : issue side
//   cdb_transmit / cdb_transmit_out, cdb_id, cdb_val         : CDB writeback
//   rob_transmit / rob_transmit_out, robid_out, flags_out,
//   wbs_out, value_out                                       : ROB writeback
//   busy : output queue full, issue must stall
module selfu_q
    import selfu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ROBID_W = 4,
    parameter int FLAG_W  = 8,
    parameter int WBS_W   = 8,
    parameter int DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_transmit,
    input  logic [DATA_W-1:0]      operand,
    input  logic [2:0][DATA_W-1:0] depvals,
    input  logic [WBS_W-1:0]       wbs,
    input  logic [FLAG_W-1:0]      flags,
    input  logic [ROBID_W-1:0]     robid,
    input  logic                   cdb_transmit,
    output logic                   cdb_transmit_out,
    output logic [ROBID_W-1:0]     cdb_id,
    output logic [DATA_W-1:0]      cdb_val,
    input  logic                   rob_transmit,
    output logic                   rob_transmit_out,
    output logic [ROBID_W-1:0]     robid_out,
    output logic [FLAG_W-1:0]      flags_out,
    output logic [WBS_W-1:0]       wbs_out,
    output logic [DATA_W-1:0]      value_out,
    output logic                   busy
`ifdef SELFU_Q_PERF_EN
    ,
    output logic [31:0]            perf_issued,
    output logic [31:0]            perf_stall,
    output logic [31:0]            perf_cdb_wait
`endif
);

    logic [DATA_W-1:0] b_sel;
    logic [DATA_W-1:0] result;

    always_comb begin
        b_sel = flags[FLAG_IMM] ? operand : depvals[1];
        if (flags[FLAG_CSEL]) begin
            result = (depvals[2] != '0) ? depvals[0] : b_sel;
        end else begin
            result = flags[FLAG_IMM] ? operand : depvals[0];
        end
    end

    fu_outq #(
        .DATA_W  (DATA_W),
        .ROBID_W (ROBID_W),
        .FLAG_W  (FLAG_W),
        .WBS_W   (WBS_W),
        .DEPTH   (DEPTH)
    ) u_outq (
        .clk              (clk),
        .rst              (rst),
        .push_valid       (input_transmit),
        .push_robid       (robid),
        .push_flags       (flags),
        .push_wbs         (wbs),
        .push_value       (result),
        // PC writebacks never go on the CDB
        .push_cdb_pend    (~flags[FLAG_WB_PC]),
        .cdb_transmit     (cdb_transmit),
        .cdb_transmit_out (cdb_transmit_out),
        .cdb_id           (cdb_id),
        .cdb_val          (cdb_val),
        .rob_transmit     (rob_transmit),
        .rob_transmit_out (rob_transmit_out),
        .robid_out        (robid_out),
        .flags_out        (flags_out),
        .wbs_out          (wbs_out),
        .value_out        (value_out),
        .busy             (busy)
`ifdef SELFU_Q_PERF_EN
        ,
        .perf_issued      (perf_issued),
        .perf_stall       (perf_stall),
        .perf_cdb_wait    (perf_cdb_wait)
`endif
    );

endmodule

// File: tb/tb_selfu_q.sv
// tb/tb_selfu_q.sv - self-checking bench for selfu_q with a queue-level reference model
module tb_selfu_q;

    localparam int DEPTH = 2;

    logic            clk;
    logic            rst;
    logic            input_transmit;
    logic [7:0]      operand;
    logic [2:0][7:0] depvals;
    logic [7:0]      wbs;
    logic [7:0]      flags;
    logic [3:0]      robid;
    logic            cdb_transmit;
    logic            cdb_transmit_out;
    logic [3:0]      cdb_id;
    logic [7:0]      cdb_val;
    logic            rob_transmit;
    logic            rob_transmit_out;
    logic [3:0]      robid_out;
    logic [7:0]      flags_out;
    logic [7:0]      wbs_out;
    logic [7:0]      value_out;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    selfu_q #(
        .DATA_W(8), .ROBID_W(4), .FLAG_W(8), .WBS_W(8), .DEPTH(DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .input_transmit   (input_transmit),
        .operand          (operand),
        .depvals          (depvals),
        .wbs              (wbs),
        .flags            (flags),
        .robid            (robid),
        .cdb_transmit     (cdb_transmit),
        .cdb_transmit_out (cdb_transmit_out),
        .cdb_id           (cdb_id),
        .cdb_val          (cdb_val),
        .rob_transmit     (rob_transmit),
        .rob_transmit_out (rob_transmit_out),
        .robid_out        (robid_out),
        .flags_out        (flags_out),
        .wbs_out          (wbs_out),
        .value_out        (value_out),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a plain queue of in-flight results ----
    typedef struct {
        logic [3:0] robid;
        logic [7:0] flags;
        logic [7:0] wbs;
        logic [7:0] value;
        bit         owe_cdb;
        bit         owe_rob;
    } ment_t;

    ment_t mq[$];

    function automatic logic [7:0] model_result(input logic [7:0] fl, input logic [7:0] op,
                                                input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c);
        logic [7:0] bsel;
        bsel = fl[1] ? op : b;
        if (fl[2]) return (c != 8'd0) ? a : bsel;
        return fl[1] ? op : a;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
        end else begin
            bit    was_full;
            ment_t h;
            ment_t n;
            was_full = (mq.size() == DEPTH);
            if (mq.size() > 0) begin
                h = mq[0];
                if (h.owe_cdb && cdb_transmit) h.owe_cdb = 1'b0;
                if (h.owe_rob && rob_transmit) h.owe_rob = 1'b0;
                if (!h.owe_cdb && !h.owe_rob) void'(mq.pop_front());
                else mq[0] = h;
            end
            if (input_transmit && !was_full) begin
                n.robid   = robid;
                n.flags   = flags;
                n.wbs     = wbs;
                n.value   = model_result(flags, operand, depvals[0], depvals[1], depvals[2]);
                n.owe_cdb = !flags[0];
                n.owe_rob = 1'b1;
                mq.push_back(n);
            end
        end
    end

    function automatic logic [63:0] act_pack();
        return {21'd0, cdb_transmit_out, cdb_id, cdb_val, rob_transmit_out,
                robid_out, flags_out, wbs_out, value_out, busy};
    endfunction

    function automatic logic [63:0] exp_pack();
        if (mq.size() == 0) return 64'd0;
        return {21'd0, mq[0].owe_cdb, mq[0].robid, mq[0].value, mq[0].owe_rob,
                mq[0].robid, mq[0].flags, mq[0].wbs, mq[0].value, (mq.size() == DEPTH)};
    endfunction

    always @(negedge clk) begin
        chk("model_cycle", act_pack(), exp_pack());
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic set_op(input logic [7:0] fl, input logic [7:0] op,
                          input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0,
                          input logic [3:0] id, input logic [7:0] wb);
        input_transmit = 1'b1;
        flags   = fl;
        operand = op;
        depvals = {d2, d1, d0};
        robid   = id;
        wbs     = wb;
    endtask

    task automatic issue(input logic [7:0] fl, input logic [7:0] op,
                         input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0,
                         input logic [3:0] id, input logic [7:0] wb);
        set_op(fl, op, d2, d1, d0, id, wb);
        @(negedge clk);
        input_transmit = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        input_transmit = 1'b0;
        operand = '0; depvals = '0; wbs = '0; flags = '0; robid = '0;
        cdb_transmit = 1'b0; rob_transmit = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", act_pack(), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Move, both readies high: visible one cycle after the push, gone the next
        cdb_transmit = 1'b1; rob_transmit = 1'b1;
        issue(8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 4'd3, 8'h11);
        chk("move_cdb_valid", cdb_transmit_out, 1);
        chk("move_cdb_id", cdb_id, 3);
        chk("move_cdb_val", cdb_val, 8'h5A);
        chk("move_value_out", value_out, 8'h5A);
        chk("move_wbs_out", wbs_out, 8'h11);
        @(negedge clk);
        chk("move_popped", {cdb_transmit_out, rob_transmit_out}, 2'b00);

        // Immediate with WB_PC: ROB only
        cdb_transmit = 1'b0; rob_transmit = 1'b0;
        issue(8'h03, 8'h7F, 8'h00, 8'h00, 8'h99, 4'd4, 8'h22);
        chk("imm_cdb_valid", cdb_transmit_out, 0);
        chk("imm_rob_valid", rob_transmit_out, 1);
        chk("imm_value", value_out, 8'h7F);
        rob_transmit = 1'b1;
        @(negedge clk);
        chk("imm_popped", rob_transmit_out, 0);

        // Conditional select, back-to-back
        cdb_transmit = 1'b1; rob_transmit = 1'b1;
        issue(8'h04, 8'h00, 8'h00, 8'h22, 8'h11, 4'd5, 8'h00);
        chk("csel_false", value_out, 8'h22);
        issue(8'h04, 8'h00, 8'h01, 8'h22, 8'h11, 4'd6, 8'h00);
        chk("csel_true", value_out, 8'h11);
        chk("csel_true_id", cdb_id, 6);
        issue(8'h06, 8'h33, 8'h00, 8'h22, 8'h11, 4'd7, 8'h00);
        chk("csel_imm_b", cdb_val, 8'h33);
        @(negedge clk);

        // Fill and stall
        cdb_transmit = 1'b0; rob_transmit = 1'b0;
        issue(8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 4'd1, 8'h00);
        chk("fill_busy_after1", busy, 0);
        issue(8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 4'd2, 8'h00);
        chk("fill_busy_after2", busy, 1);
        issue(8'h00, 8'h00, 8'h00, 8'h00, 8'h30, 4'd3, 8'h00);
        chk("fill_head_id", cdb_id, 1);
        chk("fill_busy_held", busy, 1);
        cdb_transmit = 1'b1; rob_transmit = 1'b1;
        @(negedge clk);
        chk("drain_second_id", robid_out, 2);
        chk("drain_second_val", value_out, 8'h20);
        chk("drain_busy_drop", busy, 0);
        @(negedge clk);
        chk("drain_empty", {cdb_transmit_out, rob_transmit_out}, 2'b00);

        // Split handshake: ROB first, CDB three cycles later
        cdb_transmit = 1'b0; rob_transmit = 1'b0;
        issue(8'h00, 8'h00, 8'h00, 8'h00, 8'h44, 4'd7, 8'h00);
        rob_transmit = 1'b1;
        @(negedge clk);
        chk("split_rob_fell", rob_transmit_out, 0);
        chk("split_cdb_held", cdb_transmit_out, 1);
        repeat (2) @(negedge clk);
        chk("split_cdb_still", {cdb_transmit_out, cdb_id, cdb_val}, {1'b1, 4'd7, 8'h44});
        cdb_transmit = 1'b1;
        @(negedge clk);
        chk("split_popped", cdb_transmit_out, 0);

        // Async reset mid-drain with two entries queued
        cdb_transmit = 1'b0; rob_transmit = 1'b0;
        issue(8'h00, 8'h00, 8'h00, 8'h00, 8'hA1, 4'd8, 8'h05);
        issue(8'h00, 8'h00, 8'h00, 8'h00, 8'hA2, 4'd9, 8'h06);
        cdb_transmit = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", act_pack(), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("after_reset_empty", act_pack(), 64'd0);

        // One more issue after reset to show the queue restarts cleanly
        issue(8'h00, 8'h00, 8'h00, 8'h00, 8'hC3, 4'd10, 8'h07);
        chk("post_reset_value", {robid_out, value_out}, {4'd10, 8'hC3});
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
